acs_path_metric: RTL and testbench



---
 rtl/acs_path_metric.sv | 138 +++++++++++++
 tb/tb_acs_path_metric.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acs_path_metric.sv
// acs_path_metric: one add-compare-select step for the K=3, rate-1/2 (7,5)
// Viterbi trellis. There are four states, each with one ACS unit. Candidate
// sums saturate at the metric width. When all four survivors have their MSB
// set, all four are normalised together. The result is registered with a
// latency of one cycle.

module acs_unit #(
  parameter int PM_W = 6
) (
  input  logic [PM_W-1:0] pm_p0,
  input  logic [PM_W-1:0] pm_p1,
  input  logic [1:0]      bm_p0,
  input  logic [1:0]      bm_p1,
  output logic [PM_W-1:0] pm_sel,
  output logic            dec
);
  localparam logic [PM_W-1:0] PM_MAX = '1;

  logic [PM_W:0]   sum0, sum1;
  logic [PM_W-1:0] sat0, sat1;

  // The extra sum bit only detects overflow. It never reaches the comparator.
  assign sum0 = {1'b0, pm_p0} + {{(PM_W-1){1'b0}}, bm_p0};
  assign sum1 = {1'b0, pm_p1} + {{(PM_W-1){1'b0}}, bm_p1};
  assign sat0 = sum0[PM_W] ? PM_MAX : sum0[PM_W-1:0];
  assign sat1 = sum1[PM_W] ? PM_MAX : sum1[PM_W-1:0];

  // A strict compare means that a tie keeps the even predecessor p0.
  assign dec    = (sat0 > sat1);
  assign pm_sel = dec ? sat1 : sat0;
endmodule

module acs_path_metric #(
  parameter int PM_W = 6
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_valid,
  input  logic [1:0]          i_bm_00,
  input  logic [1:0]          i_bm_01,
  input  logic [1:0]          i_bm_10,
  input  logic [1:0]          i_bm_11,
  output logic                o_valid,
  output logic [3:0]          o_decision,
  output logic [4*PM_W-1:0]   o_pm,
  output logic [1:0]          o_best_state,
  output logic                o_norm
);
  localparam int NUM_ST = 4;
  localparam logic [PM_W-1:0] PM_QTR = {2'b01, {(PM_W-2){1'b0}}};
  localparam logic [NUM_ST-1:0][PM_W-1:0] PM_INIT =
    {PM_QTR, PM_QTR, PM_QTR, {PM_W{1'b0}}};

  logic [NUM_ST-1:0][PM_W-1:0] pm_q, pm_prev, pm_sel, pm_nxt;
  logic [NUM_ST-1:0]           dec_nxt, dec_q;
  logic                        norm_nxt, norm_q;
  logic [1:0]                  best_nxt, best_q;
  logic                        vld_q;

  function automatic logic [1:0] pick_bm(input logic [1:0] code,
                                         input logic [1:0] b00, b01, b10, b11);
    case (code)
      2'b00:   pick_bm = b00;
      2'b01:   pick_bm = b01;
      2'b10:   pick_bm = b10;
      default: pick_bm = b11;
    endcase
  endfunction

  // When a start coincides with a valid step, that step begins from the init metrics.
  assign pm_prev = i_start ? PM_INIT : pm_q;

  // Next state ns = {u, s1}. The predecessors are {ns[0], 0} and {ns[0], 1}.
  // The code pair is c0 = u^s1^s0, c1 = u^s0, with u = ns[1] and s1 = ns[0].
  for (genvar n = 0; n < NUM_ST; n++) begin : g_acs
    localparam logic [1:0] NS   = 2'(n);
    localparam logic [1:0] C_P0 = {NS[1] ^ NS[0], NS[1]};
    localparam logic [1:0] C_P1 = {~(NS[1] ^ NS[0]), ~NS[1]};

    acs_unit #(.PM_W(PM_W)) u_acs (
      .pm_p0  (pm_prev[{NS[0], 1'b0}]),
      .pm_p1  (pm_prev[{NS[0], 1'b1}]),
      .bm_p0  (pick_bm(C_P0, i_bm_00, i_bm_01, i_bm_10, i_bm_11)),
      .bm_p1  (pick_bm(C_P1, i_bm_00, i_bm_01, i_bm_10, i_bm_11)),
      .pm_sel (pm_sel[n]),
      .dec    (dec_nxt[n])
    );
  end

  // Normalise. If every survivor has its MSB set, clearing the MSB subtracts half the range.
  always_comb begin
    norm_nxt = 1'b1;
    for (int n = 0; n < NUM_ST; n++) norm_nxt = norm_nxt & pm_sel[n][PM_W-1];
    pm_nxt = pm_sel;
    if (norm_nxt)
      for (int n = 0; n < NUM_ST; n++) pm_nxt[n][PM_W-1] = 1'b0;
  end

  // Find the minimum metric. The strict compare picks the lowest index among equal minima.
  always_comb begin
    best_nxt = 2'd0;
    for (int n = 1; n < NUM_ST; n++)
      if (pm_nxt[n] < pm_nxt[best_nxt]) best_nxt = 2'(n);
  end

  // Step register. Metrics hold across gaps, and a start without valid reloads the init metrics.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pm_q   <= PM_INIT;
      best_q <= 2'd0;
      dec_q  <= '0;
      norm_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= i_valid;
      if (i_valid) begin
        pm_q   <= pm_nxt;
        best_q <= best_nxt;
        dec_q  <= dec_nxt;
        norm_q <= norm_nxt;
      end else begin
        dec_q  <= '0;
        norm_q <= 1'b0;
        if (i_start) begin
          pm_q   <= PM_INIT;
          best_q <= 2'd0;
        end
      end
    end
  end

  assign o_valid      = vld_q;
  assign o_decision   = dec_q;
  assign o_pm         = pm_q;
  assign o_best_state = best_q;
  assign o_norm       = norm_q;
endmodule

// File: tb/tb_acs_path_metric.sv
// Bench for acs_path_metric. Two instances (PM_W=6 and PM_W=5) share the same
// stimulus. Directed vectors carry hand-computed expectations, and a forward
// trellis model checks every cycle.

module tb_acs_path_metric;
  logic       clk = 1'b0;
  logic       rst_n, start, valid;
  logic [1:0] bm00, bm01, bm10, bm11;

  logic        v6, n6, v5, n5;
  logic [3:0]  d6, d5;
  logic [23:0] pm6;
  logic [19:0] pm5;
  logic [1:0]  bs6, bs5;

  int n_chk = 0;
  int n_err = 0;
  int cyc_no = 0;

  // Model state. Index 0 is the PM_W=6 instance and index 1 is the PM_W=5 instance.
  int mpm [2][4];
  int mdec[2], mnorm[2], mbest[2];
  int mvld;

  always #5 clk = ~clk;

  acs_path_metric #(.PM_W(6)) dut6 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_valid(valid),
    .i_bm_00(bm00), .i_bm_01(bm01), .i_bm_10(bm10), .i_bm_11(bm11),
    .o_valid(v6), .o_decision(d6), .o_pm(pm6), .o_best_state(bs6), .o_norm(n6)
  );

  acs_path_metric #(.PM_W(5)) dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_valid(valid),
    .i_bm_00(bm00), .i_bm_01(bm01), .i_bm_10(bm10), .i_bm_11(bm11),
    .o_valid(v5), .o_decision(d5), .o_pm(pm5), .o_best_state(bs5), .o_norm(n5)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc_no, got, exp);
    end
  endtask

  function automatic int wid(input int k);
    return (k == 0) ? 6 : 5;
  endfunction

  function automatic int init_pm(input int w, input int n);
    return (n == 0) ? 0 : (1 << (w - 2));
  endfunction

  function automatic int pk(input int w, input int a, input int b, input int c, input int d);
    return a | (b << w) | (c << (2 * w)) | (d << (3 * w));
  endfunction

  function automatic int pack_m(input int k);
    return pk(wid(k), mpm[k][0], mpm[k][1], mpm[k][2], mpm[k][3]);
  endfunction

  // The model walks forward from every (state, input) pair. Previous states
  // are visited in ascending order, and a candidate replaces the survivor only
  // when it is strictly smaller, so the even predecessor wins a tie.
  task automatic model_step(input int w, input int pin[4], input int bm[4],
                            output int pout[4], output int dec, output int norm,
                            output int best);
    int maxv, half, ns, c0, c1, cand;
    maxv = (1 << w) - 1;
    half = 1 << (w - 1);
    dec  = 0;
    for (int n = 0; n < 4; n++) pout[n] = 1 << 30;
    for (int s = 0; s < 4; s++) begin
      for (int u = 0; u < 2; u++) begin
        ns   = u * 2 + s / 2;
        c0   = u ^ (s / 2) ^ (s % 2);
        c1   = u ^ (s % 2);
        cand = pin[s] + bm[c0 * 2 + c1];
        if (cand > maxv) cand = maxv;
        if (cand < pout[ns]) begin
          pout[ns] = cand;
          if (s % 2 == 1) dec = dec | (1 << ns);
          else            dec = dec & ~(1 << ns);
        end
      end
    end
    norm = 1;
    for (int n = 0; n < 4; n++) if (pout[n] < half) norm = 0;
    if (norm == 1) for (int n = 0; n < 4; n++) pout[n] = pout[n] - half;
    best = 0;
    for (int n = 1; n < 4; n++) if (pout[n] < pout[best]) best = n;
  endtask

  task automatic model_cycle(input int k, input bit st, input bit vl, input int bm[4]);
    int prev[4], nxt[4];
    int d, nm, b;
    for (int n = 0; n < 4; n++) prev[n] = st ? init_pm(wid(k), n) : mpm[k][n];
    if (vl) begin
      model_step(wid(k), prev, bm, nxt, d, nm, b);
      for (int n = 0; n < 4; n++) mpm[k][n] = nxt[n];
      mdec[k]  = d;
      mnorm[k] = nm;
      mbest[k] = b;
    end else begin
      mdec[k]  = 0;
      mnorm[k] = 0;
      if (st) begin
        for (int n = 0; n < 4; n++) mpm[k][n] = prev[n];
        mbest[k] = 0;
      end
    end
  endtask

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 4; n++) mpm[k][n] = init_pm(wid(k), n);
      mdec[k]  = 0;
      mnorm[k] = 0;
      mbest[k] = 0;
    end
    mvld = 0;
  endtask

  task automatic check_all();
    chk("vld6",  32'(v6),  32'(mvld));
    chk("dec6",  32'(d6),  32'(mdec[0]));
    chk("norm6", 32'(n6),  32'(mnorm[0]));
    chk("best6", 32'(bs6), 32'(mbest[0]));
    chk("pm6",   32'(pm6), 32'(pack_m(0)));
    chk("vld5",  32'(v5),  32'(mvld));
    chk("dec5",  32'(d5),  32'(mdec[1]));
    chk("norm5", 32'(n5),  32'(mnorm[1]));
    chk("best5", 32'(bs5), 32'(mbest[1]));
    chk("pm5",   32'(pm5), 32'(pack_m(1)));
  endtask

  // Compare one instance against hand-computed constants.
  task automatic hand(input string tag, input int k, input int vl,
                      input int p0, input int p1, input int p2, input int p3,
                      input int dec, input int best, input int norm);
    if (k == 0) begin
      chk({tag, "_vld"},  32'(v6),  32'(vl));
      chk({tag, "_pm"},   32'(pm6), 32'(pk(6, p0, p1, p2, p3)));
      chk({tag, "_dec"},  32'(d6),  32'(dec));
      chk({tag, "_best"}, 32'(bs6), 32'(best));
      chk({tag, "_norm"}, 32'(n6),  32'(norm));
    end else begin
      chk({tag, "_vld"},  32'(v5),  32'(vl));
      chk({tag, "_pm"},   32'(pm5), 32'(pk(5, p0, p1, p2, p3)));
      chk({tag, "_dec"},  32'(d5),  32'(dec));
      chk({tag, "_best"}, 32'(bs5), 32'(best));
      chk({tag, "_norm"}, 32'(n5),  32'(norm));
    end
  endtask

  // One clock: drive at negedge, advance the model, sample 1 ns after posedge.
  task automatic cyc(input bit st, input bit vl, input int a, input int b, input int c, input int d);
    int bm[4];
    @(negedge clk);
    start = st;
    valid = vl;
    bm00  = 2'(a);
    bm01  = 2'(b);
    bm10  = 2'(c);
    bm11  = 2'(d);
    bm[0] = a; bm[1] = b; bm[2] = c; bm[3] = d;
    model_cycle(0, st, vl, bm);
    model_cycle(1, st, vl, bm);
    mvld = vl ? 1 : 0;
    @(posedge clk);
    #1;
    cyc_no++;
    check_all();
  endtask

  task automatic rnd_cyc(input bit allow_start);
    bit st, vl;
    st = allow_start && ($urandom_range(49, 0) == 0);
    vl = ($urandom_range(3, 0) != 0);
    cyc(st, vl, int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
        int'($urandom_range(2, 0)), int'($urandom_range(2, 0)));
  endtask

  initial begin
    int e, nm;
    rst_n = 1'b0; start = 1'b0; valid = 1'b0;
    bm00 = 2'd0; bm01 = 2'd0; bm10 = 2'd0; bm11 = 2'd0;

    // Reset state
    #12;
    reset_model();
    check_all();
    hand("rst6", 0, 0, 0, 16, 16, 16, 0, 0, 0);
    hand("rst5", 1, 0, 0, 8, 8, 8, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First step from init, with start and valid together
    cyc(1, 1, 0, 1, 1, 2);
    hand("first6", 0, 1, 0, 17, 2, 17, 0, 0, 0);
    hand("first5", 1, 1, 0, 9, 2, 9, 0, 0, 0);

    // Start alone reloads init with o_valid low. Then run a ramp with all metrics equal to 2.
    cyc(1, 0, 0, 0, 0, 0);
    hand("init6", 0, 0, 0, 16, 16, 16, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      cyc(0, 1, 2, 2, 2, 2);
      if (k == 1) begin
        hand("ramp6", 0, 1, 2, 18, 2, 18, 0, 0, 0);
        hand("ramp5", 1, 1, 2, 10, 2, 10, 0, 0, 0);
      end else begin
        e  = (k == 16) ? 0 : 2 * k;
        nm = (k == 16) ? 1 : 0;
        hand("ramp6", 0, 1, e, e, e, e, 0, 0, nm);
        e  = (k % 8) * 2;
        nm = (k % 8 == 0) ? 1 : 0;
        hand("ramp5", 1, 1, e, e, e, e, 0, 0, nm);
      end
    end

    // Steps with gaps. Metrics and best state hold, and o_valid pulses for one cycle.
    cyc(0, 1, 0, 1, 1, 2);
    hand("gapa6", 0, 1, 0, 1, 0, 1, 4, 0, 0);
    hand("gapa5", 1, 1, 0, 1, 0, 1, 4, 0, 0);
    cyc(0, 1, 2, 2, 0, 0);
    hand("gapb6", 0, 1, 1, 0, 0, 1, 9, 1, 0);
    hand("gapb5", 1, 1, 1, 0, 0, 1, 9, 1, 0);
    repeat (3) begin
      cyc(0, 0, 1, 1, 1, 1);
      hand("hold6", 0, 0, 1, 0, 0, 1, 0, 1, 0);
      hand("hold5", 1, 0, 1, 0, 0, 1, 0, 1, 0);
    end
    cyc(0, 1, 0, 0, 0, 0);
    hand("gapc6", 0, 1, 0, 0, 0, 0, 5, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 2, 1);

    // Assert reset asynchronously in the middle of a valid step
    repeat (5) rnd_cyc(1'b0);
    @(negedge clk);
    valid = 1'b1; start = 1'b0;
    bm00 = 2'd0; bm01 = 2'd1; bm10 = 2'd1; bm11 = 2'd2;
    #2 rst_n = 1'b0;
    #1;
    reset_model();
    check_all();
    hand("arst6", 0, 0, 0, 16, 16, 16, 0, 0, 0);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b1;
    cyc(0, 1, 0, 1, 1, 2);
    hand("postrst6", 0, 1, 0, 17, 2, 17, 0, 0, 0);
    hand("postrst5", 1, 1, 0, 9, 2, 9, 0, 0, 0);

    // Mid-run start, alone and combined with valid
    repeat (5) rnd_cyc(1'b0);
    cyc(1, 0, 2, 2, 2, 2);
    hand("mstart6", 0, 0, 0, 16, 16, 16, 0, 0, 0);
    cyc(0, 1, 0, 1, 1, 2);
    hand("mstep6", 0, 1, 0, 17, 2, 17, 0, 0, 0);
    repeat (5) rnd_cyc(1'b0);
    cyc(1, 1, 0, 1, 1, 2);
    hand("mboth6", 0, 1, 0, 17, 2, 17, 0, 0, 0);
    hand("mboth5", 1, 1, 0, 9, 2, 9, 0, 0, 0);

    // Random run against the model
    for (int i = 0; i < 1000; i++) rnd_cyc(1'b1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
